// File: rtl/sync_debouncer.sv
// sync_debouncer
//   Brings a raw, bouncing, active-low push-button into the clk domain,
//   debounces the synchronised level and emits one active-low, single-cycle
//   strobe for every accepted press. Releases are debounced the same way but
//   never produce a strobe.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive clk cycles a new level must persist (>= 2)
//   CNT_WIDTH        counter width, 2**CNT_WIDTH > DEBOUNCE_CYCLES
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous reset, active-low
//   button       in   raw asynchronous button level, 0 = pressed
//   button_once  out  press strobe, low for exactly one clk cycle per press
module sync_debouncer #(
  parameter int DEBOUNCE_CYCLES = 840000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic button_once
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 sync_1;
  logic                 sync_2;
  logic                 stable;
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1      <= 1'b1;
      sync_2      <= 1'b1;
      stable      <= 1'b1;
      cnt         <= '0;
      button_once <= 1'b1;
    end else begin
      // plain two-flop chain; only sync_2 is used below
      sync_1      <= button;
      sync_2      <= sync_1;
      button_once <= 1'b1;
      if (sync_2 == stable) begin
        // any return to the accepted level throws away partial progress
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_2;
        cnt    <= '0;
        // strobe only on the released -> pressed transition
        if (!sync_2) begin
          button_once <= 1'b0;
        end
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sync_debouncer.sv
module tb_sync_debouncer;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button = 1'b1;
  logic button_once;

  int compared   = 0;
  int mismatched = 0;
  int ec         = 0;
  int strobe_cnt = 0;
  int strobe_at  = -1;
  int f          = 0;

  // reference model: a level is accepted once the last D synchronised
  // samples all differ from the currently accepted level
  logic m_s1     = 1'b1;
  logic m_s2     = 1'b1;
  logic m_stable = 1'b1;
  logic m_once   = 1'b1;
  logic hist[$];

  sync_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .button_once(button_once)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic b, input logic r);
    bit all_diff;
    if (!r) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_stable = 1'b1; m_once = 1'b1;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      m_once = 1'b1;
      all_diff = (hist.size() == D);
      foreach (hist[i]) if (hist[i] == m_stable) all_diff = 1'b0;
      if (all_diff) begin
        if (m_stable) m_once = 1'b0;
        m_stable = ~m_stable;
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic step(input logic b, input logic r);
    @(negedge clk);
    button = b;
    rst_n  = r;
    @(posedge clk);
    ec++;
    model_edge(b, r);
    #1;
    chk("button_once", {31'b0, button_once}, {31'b0, m_once});
    if (button_once === 1'b0) begin
      strobe_cnt++;
      strobe_at = ec;
    end
  endtask

  task automatic run(input logic b, input int n);
    repeat (n) step(b, 1'b1);
  endtask

  initial begin
    // 1: reset held with button released
    repeat (3) step(1'b1, 1'b0);
    chk("reset_out", {31'b0, button_once}, 32'd1);
    run(1'b1, 12);

    // 2: clean press, strobe after the 10th edge following the fall
    strobe_cnt = 0;
    f = ec + 1;
    run(1'b0, 40);
    chk("clean_cnt", strobe_cnt, 1);
    chk("clean_edge", strobe_at, f + 9);
    run(1'b1, 20);
    chk("clean_release_cnt", strobe_cnt, 1);

    // 3: bounce then hold
    strobe_cnt = 0;
    repeat (4) begin
      run(1'b0, 5);
      run(1'b1, 2);
    end
    f = ec + 1;
    run(1'b0, 20);
    chk("bounce_cnt", strobe_cnt, 1);
    chk("bounce_edge", strobe_at, f + 9);
    run(1'b1, 20);
    chk("bounce_release_cnt", strobe_cnt, 1);

    // 4: short glitch never accepted
    strobe_cnt = 0;
    run(1'b0, 6);
    run(1'b1, 20);
    chk("glitch_cnt", strobe_cnt, 0);

    // 5: press, release, press
    strobe_cnt = 0;
    run(1'b0, 30);
    chk("repress_first", strobe_cnt, 1);
    run(1'b1, 30);
    chk("repress_release", strobe_cnt, 1);
    run(1'b0, 30);
    chk("repress_second", strobe_cnt, 2);
    run(1'b1, 20);

    // 6: reset mid-count with the button held
    strobe_cnt = 0;
    run(1'b0, 6);
    step(1'b0, 1'b0);
    chk("midreset_out", {31'b0, button_once}, 32'd1);
    chk("midreset_none", strobe_cnt, 0);
    f = ec + 1;
    run(1'b0, 20);
    chk("midreset_cnt", strobe_cnt, 1);
    chk("midreset_edge", strobe_at, f + 9);
    run(1'b1, 20);

    // random runs, occasional resets, checked cycle by cycle against the model
    repeat (300) begin
      logic b;
      int n;
      b = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 14);
      repeat (n) step(b, ($urandom_range(0, 59) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
